sm_spi_adc_scan: RTL and testbench
==================================

Name: sm_spi_adc_scan

Overview:
Parametrised serial-ADC front end that scans NCH SPI slave ADCs (ambient-light and similar read-only 1-bit-out converters) round-robin over a shared sck/sdo pair with per-channel chip selects. Each frame is shifted in, the data field is extracted at a configurable bit position, and the result is held per channel with a valid strobe. Runs continuously or one scan on request. Sits on the peripheral side and feeds memory-mapped read registers.

Parameters:
NCH, 2, number of channels (cs_n lines), 1..8
DIV, 4, clk cycles per sck half-period, >=1
FRAME, 16, sck cycles (bits) per frame, 2..32
DW, 8, width of extracted data field, 1..FRAME
LSB, 4, bit index of data LSB within the captured frame (bit 0 = last bit shifted), LSB+DW<=FRAME
GAP, 16, clk cycles cs_n held high between frames, >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  continuous scan enable
start  in  1  single-scan request pulse, honoured only in IDLE with en=0
cs_n  out  NCH  per-channel chip select, active-low, at most one low
sck  out  1  serial clock, idles high
sdo  in  1  shared serial data from ADCs
data  out  NCH*DW  channel c result at [c*DW +: DW]
valid  out  1  one-cycle pulse: a channel result was just written
valid_ch  out  3  channel index written on valid (clog2, fixed 3 bits)
scan_done  out  1  one-cycle pulse coincident with valid of channel NCH-1
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, cs_n all 1, sck 1, data 0, valid/scan_done 0, valid_ch 0, channel ptr 0, shift reg 0. Applies mid-frame: frame abandoned, no valid.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE -> SETUP when en=1, or start=1; ptr=0. en has priority; start while busy ignored.
- SETUP: cs_n[ptr]=0, sck=1, DIV cycles, -> SHIFT.
- SHIFT: FRAME bits; each bit = DIV cycles sck=0 then DIV cycles sck=1. sdo sampled (shift <= {shift,sdo}) at the clk edge ending the last low-phase cycle, i.e. with sck rising. After the last high phase -> GAP.
- Timing, cs_n[ptr] falls at cycle T0: last sample at T0+DIV+(FRAME-1)*2*DIV+DIV-1; cs_n rises at T1=T0+DIV+FRAME*2*DIV. DIV=4,FRAME=16: T1=T0+132.
- Entering GAP (cycle T1): data[ptr] <= shift[LSB+DW-1:LSB], visible at T1; valid=1, valid_ch=ptr for that one cycle; scan_done=1 too if ptr=NCH-1. Other channels' data unchanged.
- GAP: all cs_n=1, sck=1, GAP cycles. Then: ptr<NCH-1 -> ptr+1, SETUP. ptr=NCH-1 -> ptr=0; SETUP if en=1, else IDLE.
- en deasserted mid-scan: current scan completes through channel NCH-1 and its GAP, then IDLE. No truncated scans.
- start during a scan, or with en=1: ignored, not queued.
- sck never toggles outside SHIFT; cs_n changes only on SETUP entry and GAP entry.
- Shift reg width FRAME; bits beyond FRAME not retained.

Test Plan:
1. NCH=1, DIV=4, FRAME=16, DW=8, LSB=4, en=1; ADC model drives 16'h0A50 MSB first, changing sdo on sck fall -> first valid at T0+132, data=8'hA5, valid_ch=0, scan_done=1, cs_n high exactly 16 cycles, next frame repeats.
2. NCH=3, channels return 0x11/0x22/0x33 -> valid_ch sequence 0,1,2, data=24'h332211 after first scan, scan_done only with ch2, one cs_n low at a time.
3. en=0, start pulse in IDLE -> exactly 3 frames, busy high from cycle after start until IDLE after ch2 GAP; second start while busy -> ignored, no extra frames.
4. en dropped during ch0 SHIFT (NCH=3) -> ch1, ch2 still complete, then IDLE, busy=0.
5. rst asserted mid-SHIFT of ch1 -> next cycle cs_n=3'b111, sck=1, data=0, no valid; re-enable restarts at ch0.
6. DIV=1, FRAME=12, DW=12, LSB=0, sdo pattern 12'hABC -> sck period 2 clk, data=12'hABC, T1=T0+25.

Source files
------------

// File: rtl/sm_spi_adc_scan.sv
// Round-robin scanner for NCH read-only SPI ADCs on a shared sck/sdo pair.
// Each frame is shifted in MSB first and a DW-bit field is latched per channel.
module sm_spi_adc_scan #(
   parameter int NCH   = 2,
   parameter int DIV   = 4,
   parameter int FRAME = 16,
   parameter int DW    = 8,
   parameter int LSB   = 4,
   parameter int GAP   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   output logic [NCH-1:0]    cs_n,
   output logic              sck,
   input  logic              sdo,
   output logic [NCH*DW-1:0] data,
   output logic              valid,
   output logic [2:0]        valid_ch,
   output logic              scan_done,
   output logic              busy
);

   localparam int CMAX = (2 * DIV > GAP) ? 2 * DIV : GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = $clog2(FRAME);

   localparam logic [CW-1:0] HALF_END = CW'(DIV - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(2 * DIV - 1);
   localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
   localparam logic [CW-1:0] HALF     = CW'(DIV);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
   localparam logic [2:0]    LAST_CH  = 3'(NCH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [BW-1:0]   bit_cnt, bit_nx;
   logic [2:0]      ptr, ptr_nx;
   logic [FRAME-1:0] shift;
   logic [DW-1:0]   data_r [NCH];
   logic [NCH-1:0]  cs_n_d;
   logic            sck_d;
   logic            unused_shift;

   // State register and datapath; cs_n and sck come straight from flops so the pins never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         ptr     <= '0;
         shift   <= '0;
         cs_n    <= '1;
         sck     <= 1'b1;
         // NOTE: result registers are cleared on reset because software may read them before the first scan.
         for (int c = 0; c < NCH; c++) data_r[c] <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples values from before the edge.
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_cnt <= bit_nx;
         ptr     <= ptr_nx;
         cs_n    <= cs_n_d;
         sck     <= sck_d;
         if (state == S_SHIFT && cnt == HALF_END)
            shift <= {shift[FRAME-2:0], sdo};
         if (state == S_SHIFT && state_nx == S_GAP)
            for (int c = 0; c < NCH; c++)
               if (ptr == 3'(c)) data_r[c] <= shift[LSB +: DW];
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      bit_nx   = bit_cnt;
      ptr_nx   = ptr;
      case (state)
         S_IDLE: begin
            cnt_nx = '0;
            ptr_nx = '0;
            if (en || start) state_nx = S_SETUP;
         end
         S_SETUP: begin
            if (cnt == HALF_END) begin
               state_nx = S_SHIFT;
               cnt_nx   = '0;
               bit_nx   = '0;
            end
         end
         S_SHIFT: begin
            if (cnt == BIT_END) begin
               cnt_nx = '0;
               if (bit_cnt == LAST_BIT) state_nx = S_GAP;
               else                     bit_nx   = bit_cnt + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt == GAP_END) begin
               cnt_nx = '0;
               if (ptr == LAST_CH) begin
                  ptr_nx   = '0;
                  state_nx = en ? S_SETUP : S_IDLE;
               end else begin
                  ptr_nx   = ptr + 3'd1;
                  state_nx = S_SETUP;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Pin levels are decoded from the next state so the registered pins line up with the state.
   always_comb begin
      cs_n_d = '1;
      for (int c = 0; c < NCH; c++)
         if ((state_nx == S_SETUP || state_nx == S_SHIFT) && ptr_nx == 3'(c))
            cs_n_d[c] = 1'b0;
      sck_d     = !(state_nx == S_SHIFT && cnt_nx < HALF);
      valid     = (state == S_GAP) && (cnt == '0);
      valid_ch  = valid ? ptr : 3'd0;
      scan_done = valid && (ptr == LAST_CH);
      busy      = (state != S_IDLE);
   end

   for (genvar g = 0; g < NCH; g++) begin : g_data
      assign data[g*DW +: DW] = data_r[g];
   end

   assign unused_shift = ^shift;

endmodule

// File: tb/tb_sm_spi_adc_scan.sv
// Bench for sm_spi_adc_scan: random ADC words per frame, scan/timing scoreboard,
// plus a second small-divider instance for the fast-clock corner.
module tb_sm_spi_adc_scan;
   localparam int NCH = 3, DIV = 4, FRAME = 16, DW = 8, LSB = 4, GAP = 16;
   localparam int LAT  = DIV + FRAME * 2 * DIV;   // cs_n fall to valid, 132
   localparam int LAT2 = 1 + 12 * 2 * 1;          // second instance, 25

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, start = 1'b0, sdo = 1'b0;
   logic [NCH-1:0]    cs_n;
   logic              sck, valid, scan_done, busy;
   logic [NCH*DW-1:0] data;
   logic [2:0]        valid_ch;

   logic        en2 = 1'b0, start2 = 1'b0, sdo2 = 1'b0;
   logic [0:0]  cs2;
   logic        sck2, valid2, done2, busy2;
   logic [11:0] data2;
   logic [2:0]  vch2;

   int checks = 0, errors = 0, cyc = 0;

   sm_spi_adc_scan #(.NCH(NCH), .DIV(DIV), .FRAME(FRAME), .DW(DW), .LSB(LSB), .GAP(GAP)) u_dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .cs_n(cs_n), .sck(sck), .sdo(sdo),
      .data(data), .valid(valid), .valid_ch(valid_ch), .scan_done(scan_done), .busy(busy));

   sm_spi_adc_scan #(.NCH(1), .DIV(1), .FRAME(12), .DW(12), .LSB(0), .GAP(3)) u_dut2 (
      .clk(clk), .rst(rst), .en(en2), .start(start2), .cs_n(cs2), .sck(sck2), .sdo(sdo2),
      .data(data2), .valid(valid2), .valid_ch(vch2), .scan_done(done2), .busy(busy2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC models and bus monitor, evaluated on levels at the falling clk edge.
   logic [NCH-1:0]   cs_prev = '1;
   logic             sck_prev = 1'b1;
   logic [FRAME-1:0] word [NCH];
   logic [FRAME-1:0] preset_q [$];
   int bit_idx = 0, cur_ch = 0, fall_cnt = 0, last_fall_cyc = 0, last_fall_ch = -1, viol = 0;

   always @(negedge clk) begin
      if (cs_prev == '1 && cs_n != '1) begin
         for (int c = 0; c < NCH; c++) if (!cs_n[c]) cur_ch = c;
         if (preset_q.size() > 0) word[cur_ch] = preset_q.pop_front();
         else                     word[cur_ch] = FRAME'($urandom);
         bit_idx = 0; fall_cnt++; last_fall_cyc = cyc; last_fall_ch = cur_ch;
      end
      if (cs_n != '1 && sck_prev && !sck && bit_idx < FRAME) begin
         sdo = word[cur_ch][FRAME-1-bit_idx];
         bit_idx++;
      end
      if ($countones(~cs_n) > 1 || (cs_n == '1 && !sck)) viol++;
      cs_prev = cs_n; sck_prev = sck;
   end

   logic        cs2_prev = 1'b1, sck2_prev = 1'b1;
   logic [11:0] pat2 = '0, word2 = '0;
   int bit2 = 0, fall2_cnt = 0, fall2_cyc = 0;

   always @(negedge clk) begin
      if (cs2_prev && !cs2[0]) begin
         word2 = pat2; bit2 = 0; fall2_cnt++; fall2_cyc = cyc;
      end
      if (!cs2[0] && sck2_prev && !sck2 && bit2 < 12) begin
         sdo2 = word2[11-bit2];
         bit2++;
      end
      cs2_prev = cs2[0]; sck2_prev = sck2;
   end

   // Reference results: the data field is the frame word shifted down by LSB.
   logic [DW-1:0] model_data [NCH];

   function automatic logic [DW-1:0] field_of(input logic [FRAME-1:0] w);
      return DW'(w >> LSB);
   endfunction

   function automatic logic [NCH*DW-1:0] model_bus();
      logic [NCH*DW-1:0] r = '0;
      for (int c = 0; c < NCH; c++) r[c*DW +: DW] = model_data[c];
      return r;
   endfunction

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin step(); if (valid) ok = 1'b1; end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin step(); if (!busy) ok = 1'b1; end
   endtask

   task automatic wait_fall(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin step(); if (fall_cnt >= target) ok = 1'b1; end
   endtask

   // One frame result: channel, field, full bus, scan_done and cs_n-to-valid latency.
   task automatic check_frame(input string tag, input int ch);
      model_data[ch] = field_of(word[ch]);
      checks++; if (valid_ch !== 3'(ch)) begin errors++; $display("FAIL %s valid_ch got %0d exp %0d", tag, valid_ch, ch); end
      checks++; if (data !== model_bus()) begin errors++; $display("FAIL %s data got %h exp %h", tag, data, model_bus()); end
      checks++; if (scan_done !== (ch == NCH - 1)) begin errors++; $display("FAIL %s scan_done got %b exp %b", tag, scan_done, ch == NCH - 1); end
      checks++; if (last_fall_ch != ch) begin errors++; $display("FAIL %s cs_line got %0d exp %0d", tag, last_fall_ch, ch); end
      checks++; if (cyc - last_fall_cyc != LAT) begin errors++; $display("FAIL %s latency got %0d exp %0d", tag, cyc - last_fall_cyc, LAT); end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; start = 1'b0; en2 = 1'b0;
      repeat (3) step();
      for (int c = 0; c < NCH; c++) model_data[c] = '0;
      checks++; if (cs_n !== 3'b111) begin errors++; $display("FAIL reset_cs_n got %b exp 111", cs_n); end
      checks++; if (sck !== 1'b1) begin errors++; $display("FAIL reset_sck got %b exp 1", sck); end
      checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
      checks++; if ({valid, scan_done, valid_ch} !== 5'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0", {valid, scan_done, valid_ch}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      rst = 1'b0;
      repeat (5) step();
      checks++; if (busy !== 1'b0 || cs_n !== 3'b111) begin errors++; $display("FAIL idle_hold busy %b cs_n %b exp 0 111", busy, cs_n); end
   endtask

   task automatic test_continuous();
      bit ok;
      int prev_valid = 0;
      preset_q.push_back(16'h0A50);
      en = 1'b1;
      for (int k = 0; k < 2 * NCH; k++) begin
         wait_valid(400, ok);
         checks++; if (!ok) begin errors++; $display("FAIL cont_timeout frame %0d", k); en = 1'b0; return; end
         check_frame("cont", k % NCH);
         if (k == 0) begin
            checks++; if (data[DW-1:0] !== 8'hA5) begin errors++; $display("FAIL cont_first got %h exp a5", data[DW-1:0]); end
         end else begin
            checks++; if (last_fall_cyc - prev_valid != GAP) begin errors++; $display("FAIL cont_gap got %0d exp %0d", last_fall_cyc - prev_valid, GAP); end
         end
         prev_valid = cyc;
         step();
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL cont_pulse valid still %b", valid); end
      end
      en = 1'b0;
      wait_idle(600, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cont_idle busy stuck %b", busy); end
   endtask

   task automatic test_start();
      bit ok;
      int f0 = fall_cnt;
      start = 1'b1; step(); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", busy); end
      for (int k = 0; k < NCH; k++) begin
         wait_valid(400, ok);
         checks++; if (!ok) begin errors++; $display("FAIL start_timeout frame %0d", k); return; end
         check_frame("start", k);
         if (k == 0) begin start = 1'b1; step(); start = 1'b0; end
      end
      wait_idle(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL start_idle busy stuck %b", busy); end
      repeat (300) step();
      checks++; if (fall_cnt - f0 != NCH) begin errors++; $display("FAIL start_frames got %0d exp %0d", fall_cnt - f0, NCH); end
   endtask

   task automatic test_en_drop();
      bit ok;
      int f0 = fall_cnt;
      en = 1'b1;
      wait_fall(f0 + 1, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_start no cs_n fall"); en = 1'b0; return; end
      repeat (20) step();
      en = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         wait_valid(400, ok);
         checks++; if (!ok) begin errors++; $display("FAIL drop_timeout frame %0d", k); return; end
         check_frame("drop", k);
      end
      repeat (GAP) step();
      checks++; if (busy !== 1'b0 || cs_n !== 3'b111) begin errors++; $display("FAIL drop_idle busy %b cs_n %b exp 0 111", busy, cs_n); end
      repeat (200) step();
      checks++; if (fall_cnt - f0 != NCH) begin errors++; $display("FAIL drop_frames got %0d exp %0d", fall_cnt - f0, NCH); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int f0 = fall_cnt;
      en = 1'b1;
      wait_valid(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout ch0"); en = 1'b0; return; end
      check_frame("rmid", 0);
      wait_fall(f0 + 2, 100, ok);
      checks++; if (!ok || last_fall_ch != 1) begin errors++; $display("FAIL rmid_ch1 fall ok %b ch %0d exp 1", ok, last_fall_ch); end
      repeat (30) step();
      rst = 1'b1; step();
      for (int c = 0; c < NCH; c++) model_data[c] = '0;
      checks++; if (cs_n !== 3'b111 || sck !== 1'b1) begin errors++; $display("FAIL rmid_pins cs_n %b sck %b exp 111 1", cs_n, sck); end
      checks++; if (data !== '0 || valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_state data %h valid %b busy %b exp 0", data, valid, busy); end
      step(); rst = 1'b0;
      f0 = fall_cnt;
      wait_fall(f0 + 1, 50, ok);
      checks++; if (!ok || last_fall_ch != 0) begin errors++; $display("FAIL rmid_restart ok %b ch %0d exp 0", ok, last_fall_ch); end
      wait_valid(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout restart"); en = 1'b0; return; end
      check_frame("rmid_re", 0);
      en = 1'b0;
      wait_idle(600, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_idle busy stuck %b", busy); end
   endtask

   task automatic test_div1();
      bit ok = 1'b0;
      logic [11:0] exp2;
      int f0 = fall2_cnt;
      pat2 = 12'hABC; en2 = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin step(); if (fall2_cnt > f0) ok = 1'b1; end
      checks++; if (!ok) begin errors++; $display("FAIL div1_start no cs_n fall"); en2 = 1'b0; return; end
      step();
      checks++; if (sck2 !== 1'b0) begin errors++; $display("FAIL div1_sck_low got %b exp 0", sck2); end
      step();
      checks++; if (sck2 !== 1'b1) begin errors++; $display("FAIL div1_sck_high got %b exp 1", sck2); end
      for (int f = 0; f < 2; f++) begin
         exp2 = pat2;
         ok = 1'b0;
         for (int i = 0; i < 60 && !ok; i++) begin step(); if (valid2) ok = 1'b1; end
         checks++; if (!ok) begin errors++; $display("FAIL div1_timeout frame %0d", f); en2 = 1'b0; return; end
         checks++; if (data2 !== exp2) begin errors++; $display("FAIL div1_data got %h exp %h", data2, exp2); end
         checks++; if (cyc - fall2_cyc != LAT2) begin errors++; $display("FAIL div1_latency got %0d exp %0d", cyc - fall2_cyc, LAT2); end
         checks++; if (done2 !== 1'b1 || vch2 !== 3'd0) begin errors++; $display("FAIL div1_done got %b/%0d exp 1/0", done2, vch2); end
         pat2 = 12'($urandom);
      end
      en2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_start();
      test_en_drop();
      test_reset_mid();
      test_div1();
      checks++; if (viol != 0) begin errors++; $display("FAIL bus_rules violations %0d exp 0", viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
